interrupt_controller: RTL and testbench

// Collects peripheral interrupt events into factor flags and masks them.

---
 rtl/interrupt_controller.sv | 119 +++++++++++
 tb/tb_interrupt_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches peripheral events into factor flags, masks them,
// and drives a one-hot request to the CPU through a three-state handshake.
module interrupt_controller #(
  parameter int unsigned NUM_SOURCES = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SOURCES-1:0] event_in,
  input  logic [2:0]             bus_addr,
  input  logic                   bus_wr,
  input  logic                   bus_rd,
  input  logic [3:0]             bus_wdata,
  output logic [3:0]             bus_rdata,
  input  logic                   cpu_int_enable,
  input  logic                   cpu_int_ack,
  output logic [NUM_SOURCES-1:0] interrupt_req
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             sel_q, sel_d;
  logic [NUM_SOURCES-1:0] factor_q, factor_d;
  logic [NUM_SOURCES-1:0] mask_q, mask_d;

  logic [NUM_SOURCES-1:0] pending;
  logic [3:0]             top_idx;
  logic                   any_pending;
  logic [15:0]            clr16;
  logic [15:0]            mask16;
  logic [15:0]            rsrc16;
  logic [3:0]             nib_base;

  assign nib_base = {bus_addr[1:0], 2'b00};

  // Nibble 3 is only three bits wide; the unused top bit is padded to 16 and dropped.
  always_comb begin
    clr16 = '0;
    if (bus_rd && !bus_addr[2]) begin
      clr16[nib_base +: 4] = '1;
    end
    factor_d = (factor_q & ~clr16[NUM_SOURCES-1:0]) | event_in;

    mask16 = {1'b0, mask_q};
    if (bus_wr && bus_addr[2]) begin
      mask16[nib_base +: 4] = bus_wdata;
    end
    mask_d = mask16[NUM_SOURCES-1:0];
  end

  always_comb begin
    rsrc16    = bus_addr[2] ? {1'b0, mask_q} : {1'b0, factor_q};
    bus_rdata = rsrc16[nib_base +: 4];
  end

  assign pending     = factor_q & mask_q;
  assign any_pending = |pending;

  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (pending[i]) begin
        top_idx = i[3:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (cpu_int_enable && any_pending) begin
          sel_d   = top_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (cpu_int_ack) begin
          state_d = SERVICE;
        end else if (!pending[sel_q] || !cpu_int_enable) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (!cpu_int_enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    interrupt_req = '0;
    if (state_q == REQ) begin
      interrupt_req[sel_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      factor_q <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      factor_q <= factor_d;
      mask_q   <= mask_d;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: directed scenarios followed by random traffic,
// checked against a flag/priority reference model.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] event_in = '0;
  logic [2:0]  bus_addr = '0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [3:0]  bus_wdata = '0;
  logic [3:0]  bus_rdata;
  logic        cpu_int_enable = 1'b0;
  logic        cpu_int_ack = 1'b0;
  logic [14:0] interrupt_req;

  interrupt_controller #(.NUM_SOURCES(15)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .event_in       (event_in),
    .bus_addr       (bus_addr),
    .bus_wr         (bus_wr),
    .bus_rd         (bus_rd),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .cpu_int_enable (cpu_int_enable),
    .cpu_int_ack    (cpu_int_ack),
    .interrupt_req  (interrupt_req)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  bit ie_v     = 1'b0;

  logic [14:0] req_exp_q[$];
  logic [3:0]  rd_exp_q[$];

  // Reference model: flags, mask, the source currently requested (-1 = none)
  // and whether a vectored interrupt is still waiting for the CPU to drop I.
  bit [14:0] m_factor = '0;
  bit [14:0] m_mask   = '0;
  int        m_src    = -1;
  bit        m_svc    = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_nibble(input int addr);
    bit [15:0] src;
    src = (addr >= 4) ? {1'b0, m_mask} : {1'b0, m_factor};
    return 4'((src >> (4 * (addr % 4))) & 16'hF);
  endfunction

  function automatic logic [14:0] m_req();
    return (m_src >= 0) ? 15'(1 << m_src) : 15'h0;
  endfunction

  task automatic m_reset();
    m_factor = '0;
    m_mask   = '0;
    m_src    = -1;
    m_svc    = 1'b0;
  endtask

  task automatic m_clock(input bit [14:0] ev, input bit rd, input bit wr, input int addr,
                         input bit [3:0] wd, input bit ie, input bit ack);
    bit [14:0] pend;
    int        top;
    pend = m_factor & m_mask;
    top  = -1;
    for (int i = 0; i < 15; i++) if (pend[i]) top = i;
    if (m_src >= 0) begin
      if (ack) begin
        m_src = -1;
        m_svc = 1'b1;
      end else if (!pend[m_src] || !ie) begin
        m_src = -1;
      end
    end else if (m_svc) begin
      if (!ie) m_svc = 1'b0;
    end else if (ie && top >= 0) begin
      m_src = top;
    end
    for (int b = 0; b < 4; b++) begin
      int idx;
      idx = 4 * (addr % 4) + b;
      if (idx < 15) begin
        if (rd && addr < 4) m_factor[idx] = 1'b0;
        if (wr && addr >= 4) m_mask[idx] = wd[b];
      end
    end
    m_factor = m_factor | ev;
  endtask

  // One clock of stimulus: called at/just after a negedge, returns at the next negedge.
  task automatic step(input logic [14:0] ev, input bit rd, input bit wr, input int addr,
                      input logic [3:0] wd, input bit ack);
    event_in       = ev;
    bus_rd         = rd;
    bus_wr         = wr;
    bus_addr       = 3'(addr);
    bus_wdata      = wd;
    cpu_int_enable = ie_v;
    cpu_int_ack    = ack;
    if (rd) rd_exp_q.push_back(m_nibble(addr));
    m_clock(ev, rd, wr, addr, wd, ie_v, ack);
    req_exp_q.push_back(m_req());
    @(negedge clk);
  endtask

  task automatic idle();                      step('0, 0, 0, 0, '0, 0); endtask
  task automatic rd(input int a);             step('0, 1, 0, a, '0, 0); endtask
  task automatic wr(input int a, input logic [3:0] d); step('0, 0, 1, a, d, 0); endtask
  task automatic ev(input logic [14:0] e);    step(e, 0, 0, 0, '0, 0); endtask
  task automatic ack();                       step('0, 0, 0, 0, '0, 1); endtask

  task automatic peek(input string name, input int a, input logic [3:0] exp);
    bus_rd   = 1'b0;
    bus_wr   = 1'b0;
    bus_addr = 3'(a);
    #1;
    check(name, {12'h0, bus_rdata}, {12'h0, exp});
  endtask

  task automatic mask_all();
    wr(4, 4'hF); wr(5, 4'hF); wr(6, 4'hF); wr(7, 4'h7);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (req_exp_q.size() == 0) check("req_queue_empty", 16'h1, 16'h0);
      else check("interrupt_req", {1'b0, interrupt_req}, {1'b0, req_exp_q.pop_front()});
      n_checks++;
      if ((interrupt_req & (interrupt_req - 15'h1)) != 15'h0) begin
        n_fail++;
        $display("FAIL onehot: got 0x%0h, expected at most one bit", interrupt_req);
      end
    end
  end

  always begin
    @(negedge clk);
    #6;
    if (mon_en && bus_rd) begin
      if (rd_exp_q.size() == 0) check("rd_queue_empty", 16'h1, 16'h0);
      else check("bus_rdata", {12'h0, bus_rdata}, {12'h0, rd_exp_q.pop_front()});
    end
  end

  initial begin
    int wait_cnt;
    repeat (3) @(negedge clk);
    check("reset_req", {1'b0, interrupt_req}, 16'h0);
    peek("reset_mask", 4, 4'h0);
    reset_n = 1'b1;
    m_reset();
    mon_en = 1'b1;
    idle();

    // Lowest source, one-cycle latency, ack withdraws
    mask_all();
    ie_v = 1'b1;
    ev(15'h0001);
    check("t1_not_yet", {1'b0, interrupt_req}, 16'h0);
    idle();
    check("t1_req", {1'b0, interrupt_req}, 16'h0001);
    ack();
    check("t1_ack", {1'b0, interrupt_req}, 16'h0);
    ie_v = 1'b0;
    idle();
    rd(0);
    ie_v = 1'b1;
    idle();

    // Priority between simultaneous sources
    ev(15'h0802);
    idle();
    check("t2_prio", {1'b0, interrupt_req}, 16'h0800);
    ack();
    ie_v = 1'b0;
    idle();
    rd(0); rd(2);
    ie_v = 1'b1;
    idle();

    // Masked source, then unmasked by a write
    wr(4, 4'h0); wr(5, 4'h0); wr(6, 4'h0); wr(7, 4'h0);
    ev(15'h4000);
    idle(); idle();
    check("t3_masked", {1'b0, interrupt_req}, 16'h0);
    peek("t3_factor3", 3, 4'h4);
    wr(7, 4'h4);
    check("t3_one_after", {1'b0, interrupt_req}, 16'h0);
    idle();
    check("t3_two_after", {1'b0, interrupt_req}, 16'h4000);
    rd(3);
    idle(); idle();
    check("t3_withdrawn", {1'b0, interrupt_req}, 16'h0);

    // Read-clear withdraws an outstanding request
    mask_all();
    ev(15'h0040);
    idle();
    check("t4_req", {1'b0, interrupt_req}, 16'h0040);
    peek("t4_nib1", 1, 4'h4);
    rd(1);
    idle(); idle();
    check("t4_withdrawn", {1'b0, interrupt_req}, 16'h0);

    // Event coincident with read-clear survives
    step(15'h0008, 1, 0, 0, '0, 0);
    peek("t5_survive", 0, 4'h8);
    rd(0);
    idle(); idle();

    // Asynchronous reset in REQ
    ev(15'h0020);
    idle();
    check("t6_req", {1'b0, interrupt_req}, 16'h0020);
    event_in = '0; bus_rd = 0; bus_wr = 0; cpu_int_ack = 0;
    m_reset();
    req_exp_q.push_back(15'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_req_async", {1'b0, interrupt_req}, 16'h0);
    peek("t6_factor", 1, 4'h0);
    peek("t6_mask", 5, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // No re-request until I is toggled
    mask_all();
    ev(15'h0001);
    idle();
    check("t7_req", {1'b0, interrupt_req}, 16'h0001);
    ack();
    idle(); idle(); idle();
    check("t7_hold", {1'b0, interrupt_req}, 16'h0);
    ie_v = 1'b0;
    idle();
    ie_v = 1'b1;
    idle();
    check("t7_rereq", {1'b0, interrupt_req}, 16'h0001);

    for (int n = 0; n < 3000; n++) begin
      logic [14:0] e;
      int          op;
      e  = ($urandom_range(0, 5) == 0) ? 15'($urandom) : 15'h0;
      op = $urandom_range(0, 5);
      if ($urandom_range(0, 19) == 0) ie_v = ~ie_v;
      step(e, op == 0, op == 1, $urandom_range(0, 7), 4'($urandom),
           $urandom_range(0, 3) == 0);
    end
    idle(); idle();

    wait_cnt = 0;
    while ((req_exp_q.size() != 0 || rd_exp_q.size() != 0) && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("drain", 16'(req_exp_q.size() + rd_exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
